ddr_dmaster_b2p: RTL

Avalon-ST bytes-to-packets converter for the DDR debug master. It sits directly downstream of the debug-master timing adapter and consumes its 8-bit ready/valid byte stream. It decodes the in-band framing protocol (SOP/EOP/channel markers and escape) into a packetised stream with start/end-of-packet and channel sidebands. That stream feeds the packets-to-transactions stage.

---
 rtl/ddr_dmaster_b2p.sv | 116 +++++++++++
 1 files changed

// File: rtl/ddr_dmaster_b2p.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_dmaster_b2p
//  Brief    : Avalon-ST bytes-to-packets converter for the DDR debug master.
//             Decodes the in-band SOP/EOP/channel/escape framing of an 8-bit
//             byte stream into packet beats with start/end/channel sidebands.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_dmaster_b2p #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    input  logic                     out_ready
);

    localparam logic [7:0] C_SOP_BYTE  = 8'h7A;
    localparam logic [7:0] C_EOP_BYTE  = 8'h7B;
    localparam logic [7:0] C_CHAN_BYTE = 8'h7C;
    localparam logic [7:0] C_ESC_BYTE  = 8'h7D;
    localparam logic [7:0] C_ESC_XOR   = 8'h20;

    logic                     esc_pend;
    logic                     sop_pend;
    logic                     eop_pend;
    logic                     chan_pend;
    logic [CHANNEL_WIDTH-1:0] chan_reg;

    logic       accept;
    logic       is_literal;
    logic [7:0] literal;
    logic       load_beat;

    // The output register is the only buffer, so a byte can only be taken
    // when that register is empty or being drained this cycle.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign load_beat = accept && is_literal && !chan_pend;

    // Classify the incoming byte: an escaped byte is always a literal.
    always_comb begin
        is_literal = 1'b0;
        literal    = in_data;
        if (esc_pend) begin
            is_literal = 1'b1;
            literal    = in_data ^ C_ESC_XOR;
        end else begin
            case (in_data)
                C_SOP_BYTE, C_EOP_BYTE, C_CHAN_BYTE, C_ESC_BYTE: is_literal = 1'b0;
                default:                                        is_literal = 1'b1;
            endcase
        end
    end

    // Framing state: escape, packet-boundary and channel-marker tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            esc_pend  <= 1'b0;
            sop_pend  <= 1'b0;
            eop_pend  <= 1'b0;
            chan_pend <= 1'b0;
            chan_reg  <= '0;
        end else if (accept) begin
            if (esc_pend) begin
                esc_pend <= 1'b0;
            end else begin
                case (in_data)
                    C_ESC_BYTE:  esc_pend  <= 1'b1;
                    C_SOP_BYTE:  sop_pend  <= 1'b1;
                    C_EOP_BYTE:  eop_pend  <= 1'b1;
                    C_CHAN_BYTE: chan_pend <= 1'b1;
                    default:     ;
                endcase
            end
            // A literal following a channel marker is the channel number.
            if (is_literal && chan_pend) begin
                chan_reg  <= literal[CHANNEL_WIDTH-1:0];
                chan_pend <= 1'b0;
            end
            // Boundary flags are consumed by the beat they annotate.
            if (load_beat) begin
                sop_pend <= 1'b0;
                eop_pend <= 1'b0;
            end
        end
    end

    // Output beat register: loads a decoded literal, drains on handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_data          <= 8'h00;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_channel       <= '0;
        end else if (load_beat) begin
            out_valid         <= 1'b1;
            out_data          <= literal;
            out_startofpacket <= sop_pend;
            out_endofpacket   <= eop_pend;
            out_channel       <= chan_reg;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
